// File: rtl/inst_rom_arbiter.sv
// Instruction-fetch arbiter: shares one synchronous instruction ROM among
// NUM_CH fetch masters. One read is issued per cycle (round-robin or fixed
// priority). A tag pipeline as deep as the ROM latency remembers which channel
// owns each in-flight read, so the returning datum is routed back to it.
module inst_rom_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ROM_LATENCY = 1,
  parameter int ARB_MODE    = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  output logic [NUM_CH-1:0]            ch_gnt,
  output logic [NUM_CH-1:0]            ch_rvalid,
  output logic [DATA_WIDTH-1:0]        ch_rdata,
  output logic                         rom_ce,
  output logic [ADDR_WIDTH-1:0]        rom_addr,
  input  logic [DATA_WIDTH-1:0]        rom_data
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // The rotating pointer only matters in round-robin mode with more than one channel.
  localparam bit RR_EN = (ARB_MODE == 0) && (NUM_CH > 1);

  // Arbitration result for the current cycle.
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;

  // Round-robin pointer: the channel that gets first look in the next search.
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // In-flight read tags; stage 0 is the youngest.
  logic [ROM_LATENCY-1:0] tag_vld_q;
  logic [IDX_W-1:0]       tag_ch_q [ROM_LATENCY];

  // Registered response.
  logic [NUM_CH-1:0]     rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Pick a winner: the requester closest (cyclically) to the search start.
  // NOTE: every variable written here gets a default before any condition, so no latch can be inferred.
  always_comb begin
    int start;
    int rank;
    int best_rank;
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    start     = 0;
    rank      = 0;
    best_rank = NUM_CH;
    // A pointer outside 0..NUM_CH-1 cannot occur, but falls back to channel 0.
    if (RR_EN && (int'(ptr_q) < NUM_CH)) begin
      start = int'(ptr_q);
    end
    for (int j = 0; j < NUM_CH; j++) begin
      rank = j - start;
      if (rank < 0) begin
        rank = rank + NUM_CH;
      end
      if (ch_req[j] && (rank < best_rank)) begin
        best_rank = rank;
        gnt_vld   = 1'b1;
        gnt_idx   = IDX_W'(j);
      end
    end
  end

  // Decode the winner into the one-hot grant and steer its address to the ROM.
  always_comb begin
    ch_gnt   = '0;
    rom_addr = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (gnt_vld && (gnt_idx == IDX_W'(j))) begin
        ch_gnt[j] = 1'b1;
        rom_addr  = ch_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign rom_ce = gnt_vld;

  // Next pointer: one past the granted channel; idle cycles leave it alone.
  // NOTE: combinational blocks use blocking '=' so later statements see earlier results in the same pass.
  always_comb begin
    ptr_d = ptr_q;
    if (RR_EN && gnt_vld) begin
      ptr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Pointer register; after reset channel 0 has first look.
  // NOTE: clocked state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Tag valid bits: cleared by reset so reads issued before reset never answer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q[0] <= gnt_vld;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
      end
    end
  end

  // Tag channel indices shift alongside the valid bits.
  // NOTE: this storage has no reset; an index is only ever consumed together with its reset-cleared valid bit.
  always_ff @(posedge clk) begin
    tag_ch_q[0] <= gnt_idx;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      tag_ch_q[i] <= tag_ch_q[i-1];
    end
  end

  // Decode the oldest tag into the one-hot valid for the owning channel.
  always_comb begin
    rvalid_d = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (tag_vld_q[ROM_LATENCY-1] && (tag_ch_q[ROM_LATENCY-1] == IDX_W'(j))) begin
        rvalid_d[j] = 1'b1;
      end
    end
  end

  // Response register: capture ROM data only when a tagged read lands; otherwise hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      if (tag_vld_q[ROM_LATENCY-1]) begin
        rdata_q <= rom_data;
      end
    end
  end

  assign ch_rvalid = rvalid_q;
  assign ch_rdata  = rdata_q;

endmodule
